// File: rtl/p2s_stream.sv
// Double-buffered parallel-to-serial converter: a shifter streams LANE_W-bit beats
// while a hold buffer takes the next word, giving bubble-free streaming.
module p2s_stream #(
  parameter int DATA_W    = 8,
  parameter int LANE_W    = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] par_data,
  input  logic              par_last,
  input  logic              par_valid,
  output logic              par_ready,
  output logic [LANE_W-1:0] ser_data,
  output logic              ser_last,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              busy
);

  localparam int NB = DATA_W / LANE_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  if ((DATA_W < 1) || ((DATA_W % LANE_W) != 0)) begin : g_param_chk
    $error("p2s_stream: DATA_W (%0d) must be >= 1 and a multiple of LANE_W (%0d)", DATA_W, LANE_W);
  end

  logic              sh_vld_q, sh_vld_d;
  logic [DATA_W-1:0] sh_data_q, sh_data_d;
  logic              sh_last_q, sh_last_d;
  logic              hb_vld_q, hb_vld_d;
  logic [DATA_W-1:0] hb_data_q, hb_data_d;
  logic              hb_last_q, hb_last_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic acc_s;
  logic beat_s;
  logic fin_s;
  logic sh_free_s;

  // Moves the next beat to the output end of the shifter.
  function automatic logic [DATA_W-1:0] shift_beat(input logic [DATA_W-1:0] d);
    if (MSB_FIRST) begin
      return d << LANE_W;
    end else begin
      return d >> LANE_W;
    end
  endfunction

  assign acc_s     = par_valid && !hb_vld_q;
  assign beat_s    = sh_vld_q && ser_ready;
  assign fin_s     = beat_s && (cnt_q == CNT_LAST);
  assign sh_free_s = !sh_vld_q || fin_s;

  always_comb begin
    sh_vld_d  = sh_vld_q;
    sh_data_d = sh_data_q;
    sh_last_d = sh_last_q;
    hb_vld_d  = hb_vld_q;
    hb_data_d = hb_data_q;
    hb_last_d = hb_last_q;
    cnt_d     = cnt_q;
    if (sh_free_s) begin
      cnt_d = CNT_ZERO;
      // Hold buffer always drains first so words never reorder.
      if (hb_vld_q) begin
        sh_vld_d  = 1'b1;
        sh_data_d = hb_data_q;
        sh_last_d = hb_last_q;
        if (acc_s) begin
          hb_vld_d  = 1'b1;
          hb_data_d = par_data;
          hb_last_d = par_last;
        end else begin
          hb_vld_d = 1'b0;
        end
      end else if (acc_s) begin
        sh_vld_d  = 1'b1;
        sh_data_d = par_data;
        sh_last_d = par_last;
      end else begin
        sh_vld_d = 1'b0;
      end
    end else begin
      if (beat_s) begin
        sh_data_d = shift_beat(sh_data_q);
        cnt_d     = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
      if (acc_s) begin
        hb_vld_d  = 1'b1;
        hb_data_d = par_data;
        hb_last_d = par_last;
      end else begin
        hb_vld_d = hb_vld_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_vld_q  <= 1'b0;
      sh_data_q <= {DATA_W{1'b0}};
      sh_last_q <= 1'b0;
      hb_vld_q  <= 1'b0;
      hb_data_q <= {DATA_W{1'b0}};
      hb_last_q <= 1'b0;
      cnt_q     <= CNT_ZERO;
    end else begin
      sh_vld_q  <= sh_vld_d;
      sh_data_q <= sh_data_d;
      sh_last_q <= sh_last_d;
      hb_vld_q  <= hb_vld_d;
      hb_data_q <= hb_data_d;
      hb_last_q <= hb_last_d;
      cnt_q     <= cnt_d;
    end
  end

  if (MSB_FIRST) begin : g_msb
    assign ser_data = sh_data_q[DATA_W-1 -: LANE_W];
  end else begin : g_lsb
    assign ser_data = sh_data_q[LANE_W-1:0];
  end

  assign par_ready = !hb_vld_q;
  assign ser_valid = sh_vld_q;
  assign ser_last  = sh_vld_q && sh_last_q && (cnt_q == CNT_LAST);
  assign busy      = sh_vld_q || hb_vld_q;

endmodule

// File: tb/tb_p2s_stream.sv
// Bench for p2s_stream: three instances (LSB/1-bit, MSB/2-bit, LSB/4-bit) checked
// against a word-to-beat reference model and directed scenarios.
module tb_p2s_stream;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [7:0] pd [3];
  logic [2:0] pl, pv, sr;
  wire  [2:0] pr, sl, sv, bz;
  wire  [0:0] sd0;
  wire  [1:0] sd1;
  wire  [3:0] sd2;
  wire  [3:0] sd [3];
  assign sd[0] = {3'b000, sd0};
  assign sd[1] = {2'b00, sd1};
  assign sd[2] = sd2;

  int lane_tab [3] = '{1, 2, 4};
  int msb_tab  [3] = '{0, 1, 0};
  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q [3][$];
  logic [4:0] obs_q [3][$];

  p2s_stream #(.DATA_W(8), .LANE_W(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .rstn(rstn), .par_data(pd[0]), .par_last(pl[0]), .par_valid(pv[0]),
    .par_ready(pr[0]), .ser_data(sd0), .ser_last(sl[0]), .ser_valid(sv[0]),
    .ser_ready(sr[0]), .busy(bz[0]));
  p2s_stream #(.DATA_W(8), .LANE_W(2), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rstn(rstn), .par_data(pd[1]), .par_last(pl[1]), .par_valid(pv[1]),
    .par_ready(pr[1]), .ser_data(sd1), .ser_last(sl[1]), .ser_valid(sv[1]),
    .ser_ready(sr[1]), .busy(bz[1]));
  p2s_stream #(.DATA_W(8), .LANE_W(4), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rstn(rstn), .par_data(pd[2]), .par_last(pl[2]), .par_valid(pv[2]),
    .par_ready(pr[2]), .ser_data(sd2), .ser_last(sl[2]), .ser_valid(sv[2]),
    .ser_ready(sr[2]), .busy(bz[2]));

  // Reference: beat b of word w is the b-th lane counted from the chosen end.
  function automatic logic [3:0] beat_of(int i, logic [7:0] w, int b);
    int l, s;
    logic [7:0] t;
    l = lane_tab[i];
    s = (msb_tab[i] != 0) ? (8 - (b + 1) * l) : (b * l);
    t = (w >> s) & ((8'd1 << l) - 8'd1);
    return t[3:0];
  endfunction

  // Records handshakes about to complete at the coming edge, then advances one cycle.
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      if (pv[i] && pr[i]) begin
        for (int b = 0; b < 8 / lane_tab[i]; b++)
          exp_q[i].push_back({pl[i] && (b == 8 / lane_tab[i] - 1), beat_of(i, pd[i], b)});
      end
      if (sv[i] && sr[i]) obs_q[i].push_back({sl[i], sd[i]});
    end
    @(negedge clk);
  endtask

  task automatic clear_q();
    for (int i = 0; i < 3; i++) begin
      exp_q[i].delete();
      obs_q[i].delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; pv = 3'b000; pl = 3'b000; sr = 3'b000;
    for (int i = 0; i < 3; i++) pd[i] = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      total++; if (pr[i] !== 1'b1) begin bad++; $display("FAIL reset_par_ready[%0d]: got %b want 1", i, pr[i]); end
      total++; if (sv[i] !== 1'b0) begin bad++; $display("FAIL reset_ser_valid[%0d]: got %b want 0", i, sv[i]); end
      total++; if (sd[i] !== 4'h0) begin bad++; $display("FAIL reset_ser_data[%0d]: got %h want 0", i, sd[i]); end
      total++; if (sl[i] !== 1'b0) begin bad++; $display("FAIL reset_ser_last[%0d]: got %b want 0", i, sl[i]); end
      total++; if (bz[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, bz[i]); end
    end
    rstn = 1'b1;
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_lsb_serial();
    logic [3:0] tab [8] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1};
    pd[0] = 8'hA5; pl[0] = 1'b0; pv[0] = 1'b1; sr[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    for (int b = 0; b < 8; b++) begin
      total++; if (sv[0] !== 1'b1) begin bad++; $display("FAIL lsb_valid beat %0d: got %b want 1", b, sv[0]); end
      total++; if (sd[0] !== tab[b]) begin bad++; $display("FAIL lsb_data beat %0d: got %h want %h", b, sd[0], tab[b]); end
      total++; if (pr[0] !== 1'b1) begin bad++; $display("FAIL lsb_par_ready beat %0d: got %b want 1", b, pr[0]); end
      tick();
    end
    total++; if (sv[0] !== 1'b0) begin bad++; $display("FAIL lsb_valid_end: got %b want 0", sv[0]); end
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL lsb_busy_end: got %b want 0", bz[0]); end
    sr[0] = 1'b0;
    clear_q();
  endtask

  task automatic test_msb_lane2();
    logic [3:0] tab [4] = '{4'd2, 4'd3, 4'd1, 4'd0};
    pd[1] = 8'hB4; pl[1] = 1'b0; pv[1] = 1'b1; sr[1] = 1'b1;
    tick();
    pv[1] = 1'b0;
    for (int b = 0; b < 4; b++) begin
      total++; if (sv[1] !== 1'b1) begin bad++; $display("FAIL msb_valid beat %0d: got %b want 1", b, sv[1]); end
      total++; if (sd[1] !== tab[b]) begin bad++; $display("FAIL msb_data beat %0d: got %h want %h", b, sd[1], tab[b]); end
      total++; if (sl[1] !== 1'b0) begin bad++; $display("FAIL msb_last beat %0d: got %b want 0", b, sl[1]); end
      tick();
    end
    total++; if (sv[1] !== 1'b0) begin bad++; $display("FAIL msb_fin: got valid %b want 0", sv[1]); end
    sr[1] = 1'b0;
    clear_q();
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [3] = '{8'h11, 8'h22, 8'h33};
    logic [3:0] tab [6] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3};
    logic       vrec [12];
    logic [3:0] drec [12];
    int n = 0;
    logic acc;
    sr[2] = 1'b1; pl[2] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      pv[2] = (n < 3);
      pd[2] = (n < 3) ? w[n] : 8'h00;
      vrec[c] = sv[2];
      drec[c] = sd[2];
      acc = pv[2] && pr[2];
      tick();
      if (acc) n++;
    end
    pv[2] = 1'b0;
    total++; if (vrec[0] !== 1'b0) begin bad++; $display("FAIL b2b_latency: valid at cycle 0 got %b want 0", vrec[0]); end
    for (int k = 0; k < 6; k++) begin
      total++; if (vrec[1 + k] !== 1'b1) begin bad++; $display("FAIL b2b_gap beat %0d: got %b want 1", k, vrec[1 + k]); end
      total++; if (drec[1 + k] !== tab[k]) begin bad++; $display("FAIL b2b_data beat %0d: got %h want %h", k, drec[1 + k], tab[k]); end
    end
    total++; if (vrec[7] !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", vrec[7]); end
    sr[2] = 1'b0;
    clear_q();
  endtask

  task automatic test_stall();
    logic acc;
    pl[0] = 1'b0; sr[0] = 1'b1;
    pd[0] = 8'hF0; pv[0] = 1'b1;
    tick();
    pd[0] = 8'h3C;
    tick();
    sr[0] = 1'b0; pd[0] = 8'h99;
    for (int c = 0; c < 4; c++) begin
      total++; if (sv[0] !== 1'b1) begin bad++; $display("FAIL stall_valid %0d: got %b want 1", c, sv[0]); end
      total++; if (sd[0] !== 4'd0) begin bad++; $display("FAIL stall_data %0d: got %h want 0", c, sd[0]); end
      total++; if (pr[0] !== 1'b0) begin bad++; $display("FAIL stall_par_ready %0d: got %b want 0", c, pr[0]); end
      total++; if (bz[0] !== 1'b1) begin bad++; $display("FAIL stall_busy %0d: got %b want 1", c, bz[0]); end
      tick();
    end
    sr[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = pv[0] && pr[0];
      tick();
      if (acc) pv[0] = 1'b0;
    end
    total++; if (obs_q[0].size() !== 24) begin bad++; $display("FAIL stall_beat_count: got %0d want 24", obs_q[0].size()); end
    for (int k = 0; k < exp_q[0].size() && k < obs_q[0].size(); k++) begin
      total++; if (obs_q[0][k] !== exp_q[0][k]) begin bad++; $display("FAIL stall_order beat %0d: got %h want %h", k, obs_q[0][k], exp_q[0][k]); end
    end
    sr[0] = 1'b0;
    clear_q();
  endtask

  task automatic test_last();
    logic [7:0] w [2];
    int n = 0;
    int nlast = 0;
    logic acc;
    w[0] = 8'($urandom); w[1] = 8'($urandom);
    sr[1] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      pv[1] = (n < 2);
      pd[1] = (n < 2) ? w[n] : 8'h00;
      pl[1] = (n == 1);
      acc = pv[1] && pr[1];
      tick();
      if (acc) n++;
    end
    pv[1] = 1'b0; pl[1] = 1'b0;
    total++; if (obs_q[1].size() !== 8) begin bad++; $display("FAIL last_beat_count: got %0d want 8", obs_q[1].size()); end
    for (int k = 0; k < obs_q[1].size(); k++) begin
      if (obs_q[1][k][4]) nlast++;
      total++; if (k < exp_q[1].size() && obs_q[1][k] !== exp_q[1][k]) begin bad++; $display("FAIL last_beat %0d: got %h want %h", k, obs_q[1][k], exp_q[1][k]); end
    end
    total++; if (nlast !== 1) begin bad++; $display("FAIL last_count: got %0d want 1", nlast); end
    total++; if (obs_q[1].size() == 8 && obs_q[1][7][4] !== 1'b1) begin bad++; $display("FAIL last_final: got %b want 1", obs_q[1][7][4]); end
    sr[1] = 1'b0;
    clear_q();
  endtask

  task automatic test_reset_mid();
    logic [7:0] w3;
    sr[0] = 1'b0; pl[0] = 1'b1;
    pd[0] = 8'($urandom); pv[0] = 1'b1;
    tick();
    pd[0] = 8'($urandom);
    tick();
    pv[0] = 1'b0;
    total++; if (pr[0] !== 1'b0) begin bad++; $display("FAIL rstmid_hold_full: got par_ready %b want 0", pr[0]); end
    rstn = 1'b0;
    #1;
    total++; if (sv[0] !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", sv[0]); end
    total++; if (pr[0] !== 1'b1) begin bad++; $display("FAIL rstmid_par_ready: got %b want 1", pr[0]); end
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", bz[0]); end
    @(negedge clk);
    rstn = 1'b1;
    clear_q();
    w3 = 8'($urandom);
    pd[0] = w3; pl[0] = 1'b0; pv[0] = 1'b1; sr[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    total++; if (sv[0] !== 1'b1) begin bad++; $display("FAIL rstmid_restart_valid: got %b want 1", sv[0]); end
    total++; if (sd[0] !== beat_of(0, w3, 0)) begin bad++; $display("FAIL rstmid_restart_beat0: got %h want %h", sd[0], beat_of(0, w3, 0)); end
    repeat (10) tick();
    total++; if (obs_q[0].size() !== 8) begin bad++; $display("FAIL rstmid_beat_count: got %0d want 8", obs_q[0].size()); end
    for (int k = 0; k < exp_q[0].size() && k < obs_q[0].size(); k++) begin
      total++; if (obs_q[0][k] !== exp_q[0][k]) begin bad++; $display("FAIL rstmid_beat %0d: got %h want %h", k, obs_q[0][k], exp_q[0][k]); end
    end
    sr[0] = 1'b0;
    clear_q();
  endtask

  task automatic test_random();
    logic       prev_stall [3];
    logic [3:0] prev_sd [3];
    logic       prev_sl [3];
    for (int i = 0; i < 3; i++) prev_stall[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (prev_stall[i]) begin
          total++; if (sv[i] !== 1'b1 || sd[i] !== prev_sd[i] || sl[i] !== prev_sl[i]) begin
            bad++; $display("FAIL rand_stall[%0d] cyc %0d: got v%b d%h l%b want v1 d%h l%b", i, c, sv[i], sd[i], sl[i], prev_sd[i], prev_sl[i]);
          end
        end
        pv[i] = ($urandom_range(0, 9) < 6);
        pd[i] = 8'($urandom);
        pl[i] = ($urandom_range(0, 3) == 0);
        sr[i] = ($urandom_range(0, 9) < 7);
        prev_stall[i] = sv[i] && !sr[i];
        prev_sd[i] = sd[i];
        prev_sl[i] = sl[i];
      end
      tick();
    end
    pv = 3'b000; sr = 3'b111;
    repeat (40) tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (obs_q[i].size() !== exp_q[i].size()) begin bad++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, obs_q[i].size(), exp_q[i].size()); end
      for (int k = 0; k < exp_q[i].size() && k < obs_q[i].size(); k++) begin
        total++; if (obs_q[i][k] !== exp_q[i][k]) begin bad++; $display("FAIL rand_beat[%0d] %0d: got %h want %h", i, k, obs_q[i][k], exp_q[i][k]); end
      end
      total++; if (bz[i] !== 1'b0) begin bad++; $display("FAIL rand_idle_busy[%0d]: got %b want 0", i, bz[i]); end
    end
    sr = 3'b000;
    clear_q();
  endtask

  initial begin
    test_reset();
    test_lsb_serial();
    test_msb_lane2();
    test_back_to_back();
    test_stall();
    test_last();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
